// File: rtl/wb_stage_buf_if.sv
// Writeback stage bus: MEM/WB intake, register-file write port and forwarding lookup.
// The stage uses the slave view; the surrounding pipeline/register file uses master.
interface wb_stage_buf_if #(
  parameter int DATA_W = 16,
  parameter int NSRC   = 4,
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [SEL_W-1:0]       in_sel;
  logic [NSRC*DATA_W-1:0] in_src;
  logic                   in_wr_en;
  logic [ADDR_W-1:0]      in_wr_addr;
  logic                   in_halt;

  logic                   rf_wr_valid;
  logic                   rf_wr_ready;
  logic [ADDR_W-1:0]      rf_wr_addr;
  logic [DATA_W-1:0]      rf_wr_data;

  logic [ADDR_W-1:0]      lk_addr;
  logic                   lk_hit;
  logic [DATA_W-1:0]      lk_data;

  modport master (
    output in_valid,
    output in_sel,
    output in_src,
    output in_wr_en,
    output in_wr_addr,
    output in_halt,
    output rf_wr_ready,
    output lk_addr,
    input  in_ready,
    input  rf_wr_valid,
    input  rf_wr_addr,
    input  rf_wr_data,
    input  lk_hit,
    input  lk_data
  );

  modport slave (
    input  in_valid,
    input  in_sel,
    input  in_src,
    input  in_wr_en,
    input  in_wr_addr,
    input  in_halt,
    input  rf_wr_ready,
    input  lk_addr,
    output in_ready,
    output rf_wr_valid,
    output rf_wr_addr,
    output rf_wr_data,
    output lk_hit,
    output lk_data
  );
endinterface

// File: rtl/wb_stage_buf.sv
// Writeback select + in-order buffer draining to the register file, with forwarding.
// Ports: clk, rst_n, bus (intake/rf/lookup), count, halted, sel_err.
module wb_stage_buf #(
  parameter int DATA_W = 16,
  parameter int NSRC   = 4,
  parameter int SEL_W  = 2,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  wb_stage_buf_if.slave  bus,
  output logic [SEL_W:0] count,
  output logic           halted,
  output logic           sel_err
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = SEL_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] NSRC_C  = CNT_W'(NSRC);

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              halt;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             headEnt;
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   idx;
  logic               haltPend;
  logic               notEmpty;
  logic               accept;
  logic               retire;
  logic               selBad;
  logic [DATA_W-1:0]  selData;

  assign headEnt  = mem[rdPtr];
  assign notEmpty = (count != '0);
  assign selBad   = ({1'b0, bus.in_sel} >= NSRC_C);

  assign bus.in_ready = (count < DEPTH_C) && !halted && !haltPend;
  assign accept       = bus.in_valid && bus.in_ready;

  // Non-writing heads leave after one cycle at the head.
  assign retire = notEmpty && (!headEnt.wen || bus.rf_wr_ready);

  assign bus.rf_wr_valid = notEmpty && headEnt.wen;
  assign bus.rf_wr_addr  = bus.rf_wr_valid ? headEnt.addr : '0;
  assign bus.rf_wr_data  = bus.rf_wr_valid ? headEnt.data : '0;

  always_comb begin
    selData = '0;
    for (int k = 0; k < NSRC; k++) begin
      if ({1'b0, bus.in_sel} == CNT_W'(k))
        selData = bus.in_src[k*DATA_W +: DATA_W];
    end
  end

  // Walk oldest to youngest so the youngest match overwrites.
  always_comb begin
    bus.lk_hit  = 1'b0;
    bus.lk_data = '0;
    idx         = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr + PTR_W'(i);
      if ((CNT_W'(i) < count) && mem[idx].wen &&
          (mem[idx].addr == bus.lk_addr)) begin
        bus.lk_hit  = 1'b1;
        bus.lk_data = mem[idx].data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      halted   <= 1'b0;
      sel_err  <= 1'b0;
      haltPend <= 1'b0;
    end else begin
      if (accept) begin
        mem[wrPtr] <= '{
          wen:  bus.in_wr_en && !selBad,
          addr: bus.in_wr_addr,
          data: selData,
          halt: bus.in_halt
        };
        wrPtr <= wrPtr + PTR_W'(1);
        if (selBad)
          sel_err <= 1'b1;
        if (bus.in_halt)
          haltPend <= 1'b1;
      end
      if (retire) begin
        rdPtr <= rdPtr + PTR_W'(1);
        if (headEnt.halt) begin
          halted   <= 1'b1;
          haltPend <= 1'b0;
        end
      end
      unique case ({accept, retire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_stage_buf.sv
// Randomized bench for wb_stage_buf against a queue-based writeback model.
// Instantiates the bus interface, NSRC=3 so select 3 is out of range.
module tb_wb_stage_buf;
  localparam int DW = 16;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int AW = 3;
  localparam int DP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW:0]   count;
  logic          halted;
  logic          selErr;

  wb_stage_buf_if #(.DATA_W(DW), .NSRC(NS), .SEL_W(SW), .ADDR_W(AW)) bus ();

  wb_stage_buf #(
    .DATA_W(DW), .NSRC(NS), .SEL_W(SW), .ADDR_W(AW), .DEPTH(DP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .count(count),
    .halted(halted),
    .sel_err(selErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          halt;
  } ent_t;

  ent_t          q[$];
  bit            mHalted;
  bit            mSelErr;
  logic [18:0]   wlog[$];
  int            nChk = 0;
  int            nFail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit mHaltPend();
    foreach (q[i]) if (q[i].halt) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic mReady();
    return (q.size() < DP) && !mHalted && !mHaltPend();
  endfunction

  task automatic compare();
    logic          eV;
    logic [AW-1:0] eA;
    logic [DW-1:0] eD;
    logic          eH;
    logic [DW-1:0] eL;
    eV = (q.size() > 0) && q[0].wen;
    eA = eV ? q[0].addr : '0;
    eD = eV ? q[0].data : '0;
    eH = 1'b0;
    eL = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].wen && q[i].addr == bus.lk_addr) begin
        eH = 1'b1;
        eL = q[i].data;
        break;
      end
    end
    chk("in_ready", 32'(bus.in_ready), 32'(mReady()));
    chk("rf_wr_valid", 32'(bus.rf_wr_valid), 32'(eV));
    chk("rf_wr_addr", 32'(bus.rf_wr_addr), 32'(eA));
    chk("rf_wr_data", 32'(bus.rf_wr_data), 32'(eD));
    chk("lk_hit", 32'(bus.lk_hit), 32'(eH));
    chk("lk_data", 32'(bus.lk_data), 32'(eL));
    chk("count", 32'(count), q.size());
    chk("halted", 32'(halted), 32'(mHalted));
    chk("sel_err", 32'(selErr), 32'(mSelErr));
    if (bus.rf_wr_valid && bus.rf_wr_ready)
      wlog.push_back({bus.rf_wr_addr, bus.rf_wr_data});
  endtask

  task automatic modelStep();
    bit   acc;
    bit   bad;
    ent_t e;
    acc = bus.in_valid && mReady();
    if (q.size() > 0 && (!q[0].wen || bus.rf_wr_ready)) begin
      if (q[0].halt) mHalted = 1'b1;
      void'(q.pop_front());
    end
    if (acc) begin
      bad    = (int'(bus.in_sel) >= NS);
      e.wen  = bus.in_wr_en && !bad;
      e.addr = bus.in_wr_addr;
      e.data = bad ? '0 : bus.in_src[int'(bus.in_sel)*DW +: DW];
      e.halt = bus.in_halt;
      if (bad) mSelErr = 1'b1;
      q.push_back(e);
    end
  endtask

  task automatic cycle();
    #1;
    compare();
    modelStep();
    @(negedge clk);
  endtask

  task automatic drv(logic v, logic [SW-1:0] s, logic [NS*DW-1:0] src,
                     logic w, logic [AW-1:0] a, logic h, logic r);
    bus.in_valid    = v;
    bus.in_sel      = s;
    bus.in_src      = src;
    bus.in_wr_en    = w;
    bus.in_wr_addr  = a;
    bus.in_halt     = h;
    bus.rf_wr_ready = r;
  endtask

  task automatic randDrive();
    bus.in_valid    = ($urandom_range(0, 3) != 0);
    bus.in_sel      = ($urandom_range(0, 15) == 0) ? 2'd3
                      : SW'($urandom_range(0, 2));
    bus.in_src      = 48'({$urandom(), $urandom()});
    bus.in_wr_en    = ($urandom_range(0, 3) != 0);
    bus.in_wr_addr  = AW'($urandom_range(0, 7));
    bus.in_halt     = ($urandom_range(0, 39) == 0);
    bus.rf_wr_ready = 1'($urandom_range(0, 1));
    bus.lk_addr     = AW'($urandom_range(0, 7));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    chk("rst rf_wr_valid", 32'(bus.rf_wr_valid), 0);
    chk("rst rf_wr_addr", 32'(bus.rf_wr_addr), 0);
    chk("rst rf_wr_data", 32'(bus.rf_wr_data), 0);
    chk("rst lk_hit", 32'(bus.lk_hit), 0);
    chk("rst lk_data", 32'(bus.lk_data), 0);
    chk("rst count", 32'(count), 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst sel_err", 32'(selErr), 0);
    q.delete();
    mHalted = 1'b0;
    mSelErr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int logSz;

  initial begin
    drv(0, 0, '0, 0, 0, 0, 1);
    bus.lk_addr = '0;
    @(negedge clk);
    doReset();

    // single write through an empty buffer
    drv(1, 2, {16'h1234, 16'h5555, 16'h6666}, 1, 3, 0, 1);
    cycle();
    chk("t1 valid", 32'(bus.rf_wr_valid), 1);
    chk("t1 addr", 32'(bus.rf_wr_addr), 3);
    chk("t1 data", 32'(bus.rf_wr_data), 32'h1234);
    chk("t1 count", 32'(count), 1);
    drv(0, 0, '0, 0, 0, 0, 1);
    cycle();
    chk("t1 drained", 32'(count), 0);

    // stall: fill, refuse third, forward, drain in order
    wlog.delete();
    drv(1, 0, 48'h000A, 1, 1, 0, 0);
    cycle();
    drv(1, 0, 48'h000B, 1, 2, 0, 0);
    cycle();
    chk("t2 ready", 32'(bus.in_ready), 0);
    chk("t2 count", 32'(count), 2);
    drv(1, 0, 48'h000C, 1, 1, 0, 0);
    cycle();
    chk("t2 held", 32'(count), 2);
    bus.lk_addr = 3'd1;
    #1;
    chk("t2 lk1 hit", 32'(bus.lk_hit), 1);
    chk("t2 lk1 data", 32'(bus.lk_data), 32'h000A);
    bus.lk_addr = 3'd2;
    #1;
    chk("t2 lk2 data", 32'(bus.lk_data), 32'h000B);
    bus.rf_wr_ready = 1'b1;
    cycle();
    cycle();
    drv(0, 0, '0, 0, 0, 0, 1);
    cycle();
    cycle();
    chk("t2 count0", 32'(count), 0);
    chk("t2 nwr", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("t2 wr0", 32'(wlog[0]), {13'h0, 3'd1, 16'h000A});
      chk("t2 wr1", 32'(wlog[1]), {13'h0, 3'd2, 16'h000B});
      chk("t2 wr2", 32'(wlog[2]), {13'h0, 3'd1, 16'h000C});
    end

    // non-writing entry retires on its own
    drv(1, 0, 48'h0077, 0, 4, 0, 0);
    cycle();
    chk("t3 valid", 32'(bus.rf_wr_valid), 0);
    chk("t3 count", 32'(count), 1);
    drv(0, 0, '0, 0, 0, 0, 0);
    cycle();
    chk("t3 count0", 32'(count), 0);

    // out-of-range select
    drv(1, 3, 48'hFFFF_FFFF_FFFF, 1, 5, 0, 1);
    cycle();
    chk("t4 sel_err", 32'(selErr), 1);
    chk("t4 valid", 32'(bus.rf_wr_valid), 0);
    drv(0, 0, '0, 0, 0, 0, 1);
    cycle();
    chk("t4 sticky", 32'(selErr), 1);

    // async reset while stalled with two entries
    drv(1, 0, 48'h0011, 1, 6, 0, 0);
    cycle();
    drv(1, 1, 48'h0022_0000, 1, 6, 0, 0);
    cycle();
    chk("t5 count", 32'(count), 2);
    drv(0, 0, '0, 0, 0, 0, 0);
    bus.lk_addr = 3'd6;
    #2;
    doReset();
    logSz = wlog.size();
    bus.rf_wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("t5 no write", wlog.size(), logSz);

    // randomized traffic; reset whenever a HALT has retired
    for (int n = 0; n < 600; n++) begin
      if (mHalted) begin
        drv(0, 0, '0, 0, 0, 0, 1);
        doReset();
      end
      randDrive();
      cycle();
    end
    drv(0, 0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle();
    doReset();

    // HALT with a write
    wlog.delete();
    drv(1, 0, 48'h00FF, 1, 7, 1, 0);
    cycle();
    chk("t6 ready", 32'(bus.in_ready), 0);
    chk("t6 halted0", 32'(halted), 0);
    chk("t6 valid", 32'(bus.rf_wr_valid), 1);
    drv(1, 0, 48'h0001, 1, 2, 0, 1);
    cycle();
    chk("t6 halted", 32'(halted), 1);
    chk("t6 count", 32'(count), 0);
    chk("t6 ready0", 32'(bus.in_ready), 0);
    chk("t6 nwr", wlog.size(), 1);
    if (wlog.size() == 1)
      chk("t6 wr", 32'(wlog[0]), {13'h0, 3'd7, 16'h00FF});
    for (int i = 0; i < 3; i++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChk, nFail);
    $finish;
  end
endmodule
